// File: rtl/psram_frame_reader.sv
// Streams a contiguous block of 16-bit PSRAM words through a 4-entry FIFO.
// Define PSRAM_READER_STATS_EN to add the stall_count output.
module psram_frame_reader #(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned AW          = 25,
  parameter int unsigned LW          = 20
) (
  input  logic          CLK50,
  input  logic          MSS_RESET_N,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] length,
  output logic          busy,
  output logic          done,
  output logic [15:0]   dout,
  output logic          dout_valid,
  input  logic          dout_ready,
`ifdef PSRAM_READER_STATS_EN
  output logic [15:0]   stall_count,
`endif
  output logic [AW-1:0] psram_address,
  input  logic [15:0]   psram_data_in,
  output logic          psram_ncs0,
  output logic          psram_noe0,
  output logic          psram_nwe,
  output logic [1:0]    psram_nbyte_en
);

  localparam int unsigned WcW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StSetup, StAccess, StRecover, StDrain} state_e;

  state_e         state;
  logic [LW-1:0]  remaining;
  logic [WcW-1:0] wait_cnt;

  logic [15:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        push;
  logic        pop;
  logic        fifo_space;
  logic        empty_after;

  assign psram_nwe      = 1'b1;
  assign psram_nbyte_en = 2'b00;

  assign dout_valid  = (count != 3'd0);
  assign dout        = dout_valid ? mem[rd_ptr] : 16'h0000;
  assign pop         = dout_valid & dout_ready;
  assign push        = (state == StAccess) && (wait_cnt == '0) && !abort;
  // Space counts a same-cycle pop so a started read always has a slot.
  assign fifo_space  = (count != 3'd4) || pop;
  assign empty_after = (count == 3'd0) || ((count == 3'd1) && pop);

  always_ff @(posedge CLK50 or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      state         <= StIdle;
      busy          <= 1'b0;
      done          <= 1'b0;
      remaining     <= '0;
      wait_cnt      <= '0;
      psram_address <= '0;
      psram_ncs0    <= 1'b1;
      psram_noe0    <= 1'b1;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state      <= StIdle;
        busy       <= 1'b0;
        psram_ncs0 <= 1'b1;
        psram_noe0 <= 1'b1;
      end else begin
        unique case (state)
          StIdle: begin
            // busy=1 in IDLE is the one-cycle exit step after an accepted start.
            if (!busy) begin
              if (start) begin
                busy          <= 1'b1;
                psram_address <= base_addr;
                remaining     <= length;
              end
            end else if (remaining == '0) begin
              done <= 1'b1;
              busy <= 1'b0;
            end else if (fifo_space) begin
              state      <= StSetup;
              psram_ncs0 <= 1'b0;
            end
          end
          StSetup: begin
            state      <= StAccess;
            psram_noe0 <= 1'b0;
            wait_cnt   <= WcW'(WAIT_CYCLES - 1);
          end
          StAccess: begin
            if (wait_cnt == '0) begin
              state         <= StRecover;
              psram_ncs0    <= 1'b1;
              psram_noe0    <= 1'b1;
              psram_address <= psram_address + 1'b1;
              remaining     <= remaining - 1'b1;
            end else begin
              wait_cnt <= wait_cnt - 1'b1;
            end
          end
          StRecover: begin
            if (remaining != '0) begin
              if (fifo_space) begin
                state      <= StSetup;
                psram_ncs0 <= 1'b0;
              end
            end else if (empty_after) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= StIdle;
            end else begin
              state <= StDrain;
            end
          end
          StDrain: begin
            if (empty_after) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= StIdle;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge CLK50 or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge CLK50) begin
    if (push) mem[wr_ptr] <= psram_data_in;
  end

`ifdef PSRAM_READER_STATS_EN
  always_ff @(posedge CLK50 or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      stall_count <= '0;
    end else if (!abort) begin
      if ((state == StIdle) && !busy && start) begin
        stall_count <= '0;
      end else if ((state == StRecover) && (remaining != '0) && !fifo_space &&
                   (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_psram_frame_reader.sv
// Directed self-checking bench for psram_frame_reader with a PSRAM model
// returning data = address[15:0] once OE has been low for WAIT_CYCLES cycles.
module tb_psram_frame_reader;
  localparam int W  = 4;
  localparam int AW = 25;
  localparam int LW = 20;

  logic          CLK50       = 1'b0;
  logic          MSS_RESET_N = 1'b0;
  logic          start       = 1'b0;
  logic          abort       = 1'b0;
  logic          dout_ready  = 1'b0;
  logic [AW-1:0] base_addr   = '0;
  logic [LW-1:0] length      = '0;
  logic          busy, done, dout_valid;
  logic [15:0]   dout, psram_data_in;
  logic [AW-1:0] psram_address;
  logic          psram_ncs0, psram_noe0, psram_nwe;
  logic [1:0]    psram_nbyte_en;
`ifdef PSRAM_READER_STATS_EN
  logic [15:0]   stall_count;
`endif

  int n_checks   = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int oe_cyc     = 0;
  int access_cnt = 0;
  int done_cnt   = 0;
  int busy_cnt   = 0;
  int addr_err   = 0;
  logic          prev_ncs0 = 1'b1;
  logic [AW-1:0] prev_addr = '0;
  logic [15:0]   rx[$];
  logic [AW-1:0] addr_q[$];

  psram_frame_reader #(.WAIT_CYCLES(W), .AW(AW), .LW(LW)) dut (
    .CLK50         (CLK50),
    .MSS_RESET_N   (MSS_RESET_N),
    .start         (start),
    .abort         (abort),
    .base_addr     (base_addr),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .dout_ready    (dout_ready),
`ifdef PSRAM_READER_STATS_EN
    .stall_count   (stall_count),
`endif
    .psram_address (psram_address),
    .psram_data_in (psram_data_in),
    .psram_ncs0    (psram_ncs0),
    .psram_noe0    (psram_noe0),
    .psram_nwe     (psram_nwe),
    .psram_nbyte_en(psram_nbyte_en)
  );

  always #10 CLK50 = ~CLK50;

  always @(posedge CLK50) begin
    cyc    <= cyc + 1;
    oe_cyc <= psram_noe0 ? 0 : oe_cyc + 1;
  end

  assign psram_data_in = (!psram_ncs0 && !psram_noe0 && oe_cyc >= W - 1) ?
                         psram_address[15:0] : 16'hDEAD;

  always @(negedge CLK50) begin
    if (MSS_RESET_N) begin
      if (!psram_ncs0 && prev_ncs0) begin
        access_cnt <= access_cnt + 1;
        addr_q.push_back(psram_address);
      end
      if (!psram_ncs0 && !prev_ncs0 && psram_address !== prev_addr) addr_err <= addr_err + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
      if (dout_valid && dout_ready) rx.push_back(dout);
    end
    prev_ncs0 <= psram_ncs0;
    prev_addr <= psram_address;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK50);
    #1;
  endtask

  task automatic kick(input logic [AW-1:0] a, input logic [LW-1:0] l);
    base_addr = a;
    length    = l;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    int i;
    seen = 1'b0;
    i    = 0;
    while (!seen && i < max_cyc) begin
      if (done) seen = 1'b1;
      else begin
        tick();
        i++;
      end
    end
  endtask

  task automatic test_reset;
    MSS_RESET_N = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({psram_ncs0, psram_noe0, psram_nwe, psram_nbyte_en, busy, done, dout_valid} !== 8'b1110_0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 11100000",
               {psram_ncs0, psram_noe0, psram_nwe, psram_nbyte_en, busy, done, dout_valid});
    end
    n_checks++;
    if (psram_address !== '0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h expected 0", psram_address);
    end
    n_checks++;
    if (dout !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_dout: got %h expected 0000", dout);
    end
    @(negedge CLK50);
    MSS_RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    int t0, a0, d0, r0, lat, done_at;
    logic [15:0] got;
    a0 = access_cnt; d0 = done_cnt; r0 = rx.size();
    dout_ready = 1'b1;
    kick(25'h0000100, 20'd4);
    t0 = cyc;
    // Second start lands in the IDLE-exit cycle and must be ignored.
    base_addr = 25'h0000777; length = 20'd9; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (dout_valid) begin
        lat = cyc - t0;
        break;
      end
      tick();
    end
    n_checks++;
    if (lat != W + 2) begin
      n_fail++;
      $display("FAIL basic_first_latency: got %0d expected %0d", lat, W + 2);
    end
    done_at = -1;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        done_at = cyc - t0;
        break;
      end
      tick();
    end
    n_checks++;
    if (done_at != 4 * (W + 2) + 1) begin
      n_fail++;
      $display("FAIL basic_done_time: got %0d expected %0d", done_at, 4 * (W + 2) + 1);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy_at_done: got %b expected 0", busy);
    end
    repeat (3) tick();
    n_checks++;
    if (rx.size() - r0 != 4) begin
      n_fail++;
      $display("FAIL basic_word_count: got %0d expected 4", rx.size() - r0);
    end
    for (int i = 0; i < 4; i++) begin
      got = (r0 + i < rx.size()) ? rx[r0 + i] : 16'hxxxx;
      n_checks++;
      if (got !== 16'h0100 + 16'(i)) begin
        n_fail++;
        $display("FAIL basic_data[%0d]: got %h expected %h", i, got, 16'h0100 + 16'(i));
      end
    end
    n_checks++;
    if (access_cnt - a0 != 4 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL basic_counts: got accesses=%0d dones=%0d expected 4 and 1",
               access_cnt - a0, done_cnt - d0);
    end
  endtask

  task automatic test_zero_length;
    int a0, d0, b0;
    a0 = access_cnt; d0 = done_cnt; b0 = busy_cnt;
    kick(25'h0001234, 20'd0);
    n_checks++;
    if ({busy, done} !== 2'b10) begin
      n_fail++;
      $display("FAIL zero_after_start: got busy,done=%b expected 10", {busy, done});
    end
    tick();
    n_checks++;
    if ({busy, done} !== 2'b01) begin
      n_fail++;
      $display("FAIL zero_done_pulse: got busy,done=%b expected 01", {busy, done});
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done_width: got %b expected 0", done);
    end
    repeat (3) tick();
    n_checks++;
    if (access_cnt - a0 != 0 || busy_cnt - b0 != 1 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL zero_counts: got accesses=%0d busy_cycles=%0d dones=%0d expected 0 1 1",
               access_cnt - a0, busy_cnt - b0, done_cnt - d0);
    end
  endtask

  task automatic test_wrap;
    int a0, r0;
    bit seen;
    logic [AW-1:0] exp_a [3];
    logic [15:0]   exp_d [3];
    logic [AW-1:0] ga;
    logic [15:0]   gd;
    exp_a = '{25'h1FFFFFE, 25'h1FFFFFF, 25'h0000000};
    exp_d = '{16'hFFFE, 16'hFFFF, 16'h0000};
    a0 = addr_q.size(); r0 = rx.size();
    dout_ready = 1'b1;
    kick(25'h1FFFFFE, 20'd3);
    wait_done(60, seen);
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wrap_done: got no done expected done within 60 cycles");
    end
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      ga = (a0 + i < addr_q.size()) ? addr_q[a0 + i] : 'x;
      gd = (r0 + i < rx.size()) ? rx[r0 + i] : 'x;
      n_checks++;
      if (ga !== exp_a[i] || gd !== exp_d[i]) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got addr=%h data=%h expected addr=%h data=%h",
                 i, ga, gd, exp_a[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int a0, d0, r0;
    bit seen;
    logic [15:0] got;
    a0 = access_cnt; d0 = done_cnt; r0 = rx.size();
    dout_ready = 1'b0;
    kick(25'h0000200, 20'd8);
    repeat (40) tick();
    n_checks++;
    if (access_cnt - a0 != 4) begin
      n_fail++;
      $display("FAIL bp_accesses_stalled: got %0d expected 4", access_cnt - a0);
    end
    n_checks++;
    if ({psram_ncs0, psram_noe0, dout_valid, busy} !== 4'b1111 || dout !== 16'h0200) begin
      n_fail++;
      $display("FAIL bp_stalled_state: got ncs,noe,valid,busy=%b dout=%h expected 1111 0200",
               {psram_ncs0, psram_noe0, dout_valid, busy}, dout);
    end
`ifdef PSRAM_READER_STATS_EN
    n_checks++;
    if (stall_count == 16'h0000) begin
      n_fail++;
      $display("FAIL bp_stall_count: got %0d expected nonzero", stall_count);
    end
`endif
    dout_ready = 1'b1;
    wait_done(120, seen);
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL bp_done: got no done expected done within 120 cycles");
    end
    repeat (2) tick();
    n_checks++;
    if (rx.size() - r0 != 8 || access_cnt - a0 != 8 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL bp_counts: got words=%0d accesses=%0d dones=%0d expected 8 8 1",
               rx.size() - r0, access_cnt - a0, done_cnt - d0);
    end
    for (int i = 0; i < 8; i++) begin
      got = (r0 + i < rx.size()) ? rx[r0 + i] : 16'hxxxx;
      n_checks++;
      if (got !== 16'h0200 + 16'(i)) begin
        n_fail++;
        $display("FAIL bp_data[%0d]: got %h expected %h", i, got, 16'h0200 + 16'(i));
      end
    end
  endtask

  task automatic test_abort;
    int a0, d0, r0;
    bit seen;
    logic [15:0] got;
    a0 = access_cnt; d0 = done_cnt; r0 = rx.size();
    dout_ready = 1'b1;
    kick(25'h0000300, 20'd5);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (access_cnt - a0 == 2 && !psram_noe0) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL abort_reach_access: got not found expected ACCESS of word 2");
    end
    // Simultaneous start must lose to abort.
    abort = 1'b1; start = 1'b1; base_addr = 25'h0000999; length = 20'd3;
    tick();
    abort = 1'b0; start = 1'b0;
    n_checks++;
    if ({psram_ncs0, psram_noe0, dout_valid, busy} !== 4'b1100) begin
      n_fail++;
      $display("FAIL abort_next_cycle: got ncs,noe,valid,busy=%b expected 1100",
               {psram_ncs0, psram_noe0, dout_valid, busy});
    end
    repeat (20) tick();
    n_checks++;
    if (access_cnt - a0 != 2 || done_cnt - d0 != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_quiet: got accesses=%0d dones=%0d busy=%b expected 2 0 0",
               access_cnt - a0, done_cnt - d0, busy);
    end
    kick(25'h0000400, 20'd2);
    wait_done(60, seen);
    repeat (2) tick();
    n_checks++;
    if (!seen || rx.size() - r0 != 3) begin
      n_fail++;
      $display("FAIL abort_restart: got done=%b words=%0d expected 1 3", seen, rx.size() - r0);
    end
    for (int i = 0; i < 3; i++) begin
      got = (r0 + i < rx.size()) ? rx[r0 + i] : 16'hxxxx;
      n_checks++;
      if (got !== ((i == 0) ? 16'h0300 : 16'h0400 + 16'(i - 1))) begin
        n_fail++;
        $display("FAIL abort_data[%0d]: got %h expected %h", i, got,
                 (i == 0) ? 16'h0300 : 16'h0400 + 16'(i - 1));
      end
    end
  endtask

  task automatic test_reset_mid;
    int a0, r0;
    bit seen;
    logic [15:0] got;
    a0 = access_cnt; r0 = rx.size();
    dout_ready = 1'b1;
    kick(25'h0000500, 20'd3);
    for (int i = 0; i < 20; i++) begin
      if (!psram_noe0) break;
      tick();
    end
    #4;
    MSS_RESET_N = 1'b0;
    #1;
    n_checks++;
    if ({psram_ncs0, psram_noe0, psram_nwe, psram_nbyte_en, busy, done, dout_valid} !== 8'b1110_0000 ||
        psram_address !== '0 || dout !== 16'h0000) begin
      n_fail++;
      $display("FAIL midreset_async: got ctrl=%b addr=%h dout=%h expected 11100000 0 0000",
               {psram_ncs0, psram_noe0, psram_nwe, psram_nbyte_en, busy, done, dout_valid},
               psram_address, dout);
    end
    @(negedge CLK50);
    MSS_RESET_N = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (busy !== 1'b0 || psram_ncs0 !== 1'b1 || access_cnt - a0 != 1) begin
      n_fail++;
      $display("FAIL midreset_idle: got busy=%b ncs=%b accesses=%0d expected 0 1 1",
               busy, psram_ncs0, access_cnt - a0);
    end
    kick(25'h0000600, 20'd1);
    wait_done(30, seen);
    repeat (2) tick();
    got = (rx.size() == r0 + 1) ? rx[r0] : 16'hxxxx;
    n_checks++;
    if (!seen || got !== 16'h0600) begin
      n_fail++;
      $display("FAIL midreset_restart: got done=%b data=%h words=%0d expected 1 0600 1",
               seen, got, rx.size() - r0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_wrap();
    test_backpressure();
    test_abort();
    test_reset_mid();
    n_checks++;
    if (addr_err != 0) begin
      n_fail++;
      $display("FAIL addr_stable: got %0d changes while selected expected 0", addr_err);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/psram_frame_reader.md
# psram_frame_reader

Reads a contiguous block of 16-bit words from the external asynchronous PSRAM and streams them out through a valid/ready interface with a 4-entry output FIFO. It is the read-side counterpart to the capture path that writes camera frames into PSRAM, sitting beside the PSRAM pins in TOPLEVEL and feeding frame data back to the MSS/Ethernet path. It drives only chip-select 0 and output-enable 0; write-enable stays inactive.

## Interface
- WAIT_CYCLES, 4: clock cycles OE is held low per access (minimum 1).
- AW, 25: PSRAM word-address width.
- LW, 20: transfer-length width in words.
- CLK50  in  1  system clock, 50 MHz.
- MSS_RESET_N  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- abort  in  1  cancels the transfer; takes priority over all other inputs except reset.
- base_addr  in  AW  first word address, latched on an accepted start.
- length  in  LW  number of words to read, latched on an accepted start.
- busy  out  1  high from the accepted start until done or abort completes.
- done  out  1  one-cycle pulse when the last word is accepted downstream.
- dout  out  16  FIFO head data.
- dout_valid  out  1  FIFO not empty.
- dout_ready  in  1  downstream accepts dout when it is high together with dout_valid.
- psram_address  out  AW  word address.
- psram_data_in  in  16  PSRAM data bus (tristate resolved above this block).
- psram_ncs0  out  1  chip select, active low.
- psram_noe0  out  1  output enable, active low.
- psram_nwe  out  1  held at 1.
- psram_nbyte_en  out  2  held at 2'b00 (both bytes).

## Operation
- States: IDLE, SETUP, ACCESS, RECOVER, DRAIN.
- IDLE -> start=1: latch base_addr and length, then set busy. If length=0, pulse done in the next cycle and stay in IDLE without any PSRAM access. Otherwise go to SETUP when FIFO space is available.
- SETUP: one cycle. ncs0=0, noe0=1, address stable.
- ACCESS: WAIT_CYCLES cycles with ncs0=0 and noe0=0. On the rising edge that ends the last ACCESS cycle, psram_data_in is pushed into the FIFO.
- RECOVER: one cycle with ncs0=1 and noe0=1. The address increments by 1 and wraps modulo 2^AW; the remaining count decrements.
  - remaining > 0 and FIFO has space: go to SETUP.
  - remaining > 0 and FIFO is full: wait in RECOVER with ncs0 and noe0 high.
  - remaining = 0: go to DRAIN.
- FIFO space: SETUP is entered only if occupancy, counting any entry popped in the same cycle, is at most 3. This guarantees every started read has a slot.
- DRAIN: wait until the FIFO is empty. done=1 in the cycle after the last pop; busy drops in the same cycle. Then go to IDLE.
- abort: on the next edge, ncs0=1, noe0=1, the FIFO is flushed (dout_valid=0), busy=0, no done pulse, state = IDLE. Any in-flight access is discarded.
- start while busy is ignored. start and abort in the same cycle: abort wins and start is ignored.
- FIFO push and pop in the same cycle leave occupancy unchanged.

## Timing
- Reset values: psram_ncs0=1, psram_noe0=1, psram_nwe=1, psram_nbyte_en=2'b00, psram_address=0, busy=0, done=0, dout_valid=0, dout=0. Reset mid-transfer returns to these values immediately (asynchronous).
- All PSRAM outputs are registered.
- Per word with no backpressure: WAIT_CYCLES+2 cycles; the default is 6 cycles = 120 ns.
- First word: dout_valid rises WAIT_CYCLES+2 cycles after the start edge (1 IDLE-exit cycle + SETUP + ACCESS).
- ncs0 is high for at least 1 cycle between consecutive accesses.
- psram_address changes only while ncs0=1.

## Configuration
- PSRAM_READER_STATS_EN defined:
  - Adds output stall_count[15:0], which counts RECOVER cycles spent waiting on a full FIFO.
  - The count clears on an accepted start and saturates at 16'hFFFF.
  - Reset value is 0.
- PSRAM_READER_STATS_EN undefined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
- base_addr=0x000100, length=4, dout_ready=1, memory model returns data = address[15:0]:
  - dout sequence 0x0100, 0x0101, 0x0102, 0x0103.
  - done pulses once, 24 cycles of PSRAM activity plus drain.
- length=0 -> done pulses 1 cycle after start; ncs0 never goes low; busy is high for exactly 1 cycle.
- base_addr=0x1FFFFFE, length=3 -> addresses 0x1FFFFFE, 0x1FFFFFF, 0x0000000.
- dout_ready=0 for 40 cycles with length=8:
  - exactly 4 accesses occur, then ncs0 stays high.
  - Releasing ready delivers all 8 words in order with no duplicates.
  - stall_count>0 when PSRAM_READER_STATS_EN is defined.
- abort asserted during the ACCESS state of word 2 of 5 -> next cycle ncs0=1, noe0=1, dout_valid=0, busy=0; no done pulse; a new start then reads correctly.
- MSS_RESET_N pulsed low mid-ACCESS -> all outputs take their reset values asynchronously; the block is idle after release.
